victim_writeback_buffer: RTL

Write-back buffer that takes dirty cache lines leaving the victim cache and drains each one to memory as a single AXI4 INCR burst. It sits directly downstream of the victim cache, between the data-cache refill/evict logic and the AXI write channels. It also provides an address-match lookup, so a read miss can be served from a line that is queued or in flight instead of stale memory.

---
 rtl/victim_writeback_buffer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/victim_writeback_buffer.sv
// rtl/victim_writeback_buffer.sv - queue of evicted dirty lines drained to memory as AXI4 INCR bursts
//
// Holds up to DEPTH dirty lines from the victim cache and writes each one out as a
// single LINE_WORD_NUM-beat INCR burst. A line stays hit-able until its write response
// arrives, so a read miss can be served from the buffer instead of stale memory.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   push_*                      victim line input (valid/ready handshake)
//   query_tag/index -> query_hit/query_data   combinational lookup, youngest match wins
//   empty                       nothing queued and no burst in progress
//   wb_error                    sticky, set by any non-OKAY write response
//   aw*/w*/b*                   AXI4 write address, data and response channels
module victim_writeback_buffer #(
    parameter int DEPTH         = 2,
    parameter int TAG_WIDTH     = 20,
    parameter int INDEX_WIDTH   = 6,
    parameter int LINE_WORD_NUM = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          push_valid,
    output logic                          push_ready,
    input  logic [TAG_WIDTH-1:0]          push_tag,
    input  logic [INDEX_WIDTH-1:0]        push_index,
    input  logic [LINE_WORD_NUM*32-1:0]   push_data,
    input  logic [TAG_WIDTH-1:0]          query_tag,
    input  logic [INDEX_WIDTH-1:0]        query_index,
    output logic                          query_hit,
    output logic [LINE_WORD_NUM*32-1:0]   query_data,
    output logic                          empty,
    output logic                          wb_error,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [31:0]                   awaddr,
    output logic [7:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic [1:0]                    awburst,
    output logic                          wvalid,
    input  logic                          wready,
    output logic [31:0]                   wdata,
    output logic [3:0]                    wstrb,
    output logic                          wlast,
    input  logic                          bvalid,
    output logic                          bready,
    input  logic [1:0]                    bresp
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(LINE_WORD_NUM);
    localparam int OFF_W  = BEAT_W + 2;
    localparam int ADDR_W = TAG_WIDTH + INDEX_WIDTH + OFF_W;
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(LINE_WORD_NUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         tail;
    logic [CNT_W-1:0]         count;
    logic [BEAT_W-1:0]        beat;
    logic [DEPTH-1:0]         valid;
    logic [TAG_WIDTH-1:0]     tag_mem   [DEPTH];
    logic [INDEX_WIDTH-1:0]   index_mem [DEPTH];
    logic [31:0]              data_mem  [DEPTH][LINE_WORD_NUM];

    logic                     push_fire;
    logic                     pop_fire;
    logic [ADDR_W-1:0]        head_addr;
    logic [PTR_W-1:0]         scan_ptr;
    logic [PTR_W-1:0]         hit_ptr;

    assign push_ready = (count != FULL_COUNT);
    assign push_fire  = push_valid && push_ready;
    // The head entry retires only on the B handshake, never earlier.
    assign pop_fire   = (state == S_B) && bvalid;
    assign empty      = (count == '0) && (state == S_IDLE);
    assign head_addr  = {tag_mem[head], index_mem[head], {OFF_W{1'b0}}};

    assign awlen   = 8'(LINE_WORD_NUM - 1);
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign wstrb   = 4'hF;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            beat     <= '0;
            valid    <= '0;
            wb_error <= 1'b0;
        end else begin
            state <= state_next;
            if (push_fire) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (pop_fire) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
                if (bresp != 2'b00) begin
                    wb_error <= 1'b1;
                end
            end
            count <= count + CNT_W'(push_fire) - CNT_W'(pop_fire);
            if ((state == S_AW) && awready) begin
                beat <= '0;
            end else if (wvalid && wready) begin
                beat <= beat + 1'b1;
            end
        end
    end

    // Line storage needs no reset: entries are only observed through valid bits.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            tag_mem[tail]   <= push_tag;
            index_mem[tail] <= push_index;
            for (int w = 0; w < LINE_WORD_NUM; w++) begin
                data_mem[tail][w] <= push_data[w*32 +: 32];
            end
        end
    end

    always_comb begin
        state_next = state;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        awaddr     = '0;
        wdata      = '0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    state_next = S_AW;
                end
            end
            S_AW: begin
                awvalid = 1'b1;
                awaddr  = 32'(head_addr);
                if (awready) begin
                    state_next = S_W;
                end
            end
            S_W: begin
                wvalid = 1'b1;
                wdata  = data_mem[head][beat];
                if ((beat == LAST_BEAT) && wready) begin
                    state_next = S_B;
                end
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        wlast = (beat == LAST_BEAT) && wvalid;
    end

    // Scan from head to tail so a later (younger) match overrides an older one.
    always_comb begin
        query_hit  = 1'b0;
        hit_ptr    = '0;
        scan_ptr   = '0;
        query_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_ptr = head + PTR_W'(i);
            if (valid[scan_ptr] && (tag_mem[scan_ptr] == query_tag) &&
                (index_mem[scan_ptr] == query_index)) begin
                query_hit = 1'b1;
                hit_ptr   = scan_ptr;
            end
        end
        if (query_hit) begin
            for (int w = 0; w < LINE_WORD_NUM; w++) begin
                query_data[w*32 +: 32] = data_mem[hit_ptr][w];
            end
        end
    end

endmodule
